// File: rtl/adio_adc_rx.sv
// adio_adc_rx: master-mode receiver for a left-justified codec ADC stream.
// It generates BCK and LRCK, deserializes each channel word MSB first, and keeps a peak-hold meter.
// Latency: oValid and a new oLEFT/oRIGHT pair appear one clock after the last right-channel sample edge.
// Backpressure: none. Words are presented once, as a one-cycle strobe, and then held until the next pair.

module adio_adc_rx #(
  parameter int REF_CLK     = 18432000,
  parameter int SAMPLE_RATE = 48000,
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNEL_NUM = 2
) (
  input  logic                  iCLK_18_4,
  input  logic                  iRST_N,
  input  logic                  iAUD_ADCDAT,
  input  logic                  iPeak_clr,
  output logic                  oAUD_BCK,
  output logic                  oAUD_ADCLRCK,
  output logic [DATA_WIDTH-1:0] oLEFT,
  output logic [DATA_WIDTH-1:0] oRIGHT,
  output logic                  oValid,
  output logic [DATA_WIDTH-2:0] oPeak
);

  // Reference clocks per BCK half-period, and per LRCK half-period.
  localparam int BCK_DIV  = REF_CLK / (SAMPLE_RATE * DATA_WIDTH * CHANNEL_NUM * 2);
  localparam int LRCK_DIV = REF_CLK / (SAMPLE_RATE * 2);
  localparam int BCK_CW   = $clog2(BCK_DIV + 1);
  localparam int LRCK_CW  = $clog2(LRCK_DIV + 1);
  // The bit counter has to hold DATA_WIDTH itself, because it saturates at that value.
  localparam int BIT_CW   = $clog2(DATA_WIDTH + 1);

  localparam logic [BCK_CW-1:0]  BCK_TOP  = BCK_CW'(BCK_DIV - 1);
  localparam logic [LRCK_CW-1:0] LRCK_TOP = LRCK_CW'(LRCK_DIV - 1);
  localparam logic [BIT_CW-1:0]  BIT_FULL = BIT_CW'(DATA_WIDTH);
  localparam logic [BIT_CW-1:0]  BIT_LAST = BIT_CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } state_t;

  // Clock dividers
  logic [BCK_CW-1:0]  bck_cnt_q,  bck_cnt_d;
  logic [LRCK_CW-1:0] lrck_cnt_q, lrck_cnt_d;
  logic               bck_q,  bck_d;
  logic               lrck_q, lrck_d;

  // Deserializer
  logic [BIT_CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;

  // Frame tracking
  state_t                state_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  left_ok_q;
  logic                  done_q;

  // Output registers
  logic [DATA_WIDTH-1:0] left_q;
  logic [DATA_WIDTH-1:0] right_q;
  logic                  valid_q;
  logic [DATA_WIDTH-2:0] peak_q, peak_d;

  // Decoded events
  logic bck_wrap;
  logic lrck_wrap;
  logic lrck_rise;
  logic lrck_fall;
  logic sample_edge;
  logic bit_take;
  logic word_end;

  logic [DATA_WIDTH-2:0] mag_l;
  logic [DATA_WIDTH-2:0] mag_r;
  logic [DATA_WIDTH-2:0] mag_max;

  // Returns |x| as an unsigned value. The most negative input saturates to all ones,
  // because its true magnitude does not fit in DATA_WIDTH-1 bits.
  function automatic logic [DATA_WIDTH-2:0] magnitude(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] neg;
    neg = -x;
    if (!x[DATA_WIDTH-1]) begin
      return x[DATA_WIDTH-2:0];
    end else if (neg[DATA_WIDTH-1]) begin
      return '1;
    end else begin
      return neg[DATA_WIDTH-2:0];
    end
  endfunction

  assign bck_wrap    = (bck_cnt_q == BCK_TOP);
  assign lrck_wrap   = (lrck_cnt_q == LRCK_TOP);
  assign lrck_rise   = lrck_wrap && !lrck_q;
  assign lrck_fall   = lrck_wrap &&  lrck_q;
  // Data is taken on the clock that raises BCK, so the codec has had a full BCK low phase to settle it.
  assign sample_edge = bck_wrap && !bck_q;
  // Edges past the word length are ignored. An LRCK toggle takes priority over a coincident sample edge.
  assign bit_take    = sample_edge && !lrck_wrap && (bit_cnt_q < BIT_FULL);
  assign word_end    = bit_take && (bit_cnt_q == BIT_LAST);

  // Next-state values for the dividers, bit counter and shifter
  always_comb begin
    bck_cnt_d  = bck_wrap  ? '0 : bck_cnt_q  + BCK_CW'(1);
    lrck_cnt_d = lrck_wrap ? '0 : lrck_cnt_q + LRCK_CW'(1);
    bck_d      = bck_wrap  ? ~bck_q  : bck_q;
    lrck_d     = lrck_wrap ? ~lrck_q : lrck_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    if (lrck_wrap) begin
      bit_cnt_d = '0;
    end else if (bit_take) begin
      bit_cnt_d = bit_cnt_q + BIT_CW'(1);
      shift_d   = {shift_q[DATA_WIDTH-2:0], iAUD_ADCDAT};
    end
  end

  // Free-running dividers. LRCK is an exact multiple of BCK, so its edges fall on BCK falling edges.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      bck_cnt_q  <= '0;
      lrck_cnt_q <= '0;
      bck_q      <= 1'b0;
      lrck_q     <= 1'b0;
    end else begin
      bck_cnt_q  <= bck_cnt_d;
      lrck_cnt_q <= lrck_cnt_d;
      bck_q      <= bck_d;
      lrck_q     <= lrck_d;
    end
  end

  // Serial-to-parallel shifter with a per-half-frame bit counter
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Frame FSM. Capture is aligned to the first LRCK rising edge, so the partial
  // half-frame seen after reset is thrown away. A right word is flagged done only
  // when the left word before it completed.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= SYNC;
      hold_q    <= '0;
      left_ok_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SYNC: begin
          if (lrck_rise) begin
            state_q   <= LEFT;
            left_ok_q <= 1'b0;
          end
        end
        LEFT: begin
          if (lrck_fall) begin
            state_q <= RIGHT;
          end else if (word_end) begin
            hold_q    <= shift_d;
            left_ok_q <= 1'b1;
          end
        end
        RIGHT: begin
          if (lrck_rise) begin
            state_q   <= LEFT;
            left_ok_q <= 1'b0;
          end else if (word_end && left_ok_q) begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= SYNC;
          left_ok_q <= 1'b0;
        end
      endcase
    end
  end

  // Peak candidates are taken from the pair that is being published this cycle.
  always_comb begin
    mag_l   = magnitude(hold_q);
    mag_r   = magnitude(shift_q);
    mag_max = (mag_l > mag_r) ? mag_l : mag_r;
  end

  // Peak-hold next value. A clear that lands on an update still keeps the new pair's peak.
  always_comb begin
    peak_d = peak_q;
    if (done_q) begin
      if (iPeak_clr || (mag_max > peak_q)) begin
        peak_d = mag_max;
      end
    end else if (iPeak_clr) begin
      peak_d = '0;
    end
  end

  // Publish the completed pair. The shifter stays stable until the next sample edge, which is many clocks away.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      peak_q  <= '0;
    end else begin
      valid_q <= done_q;
      peak_q  <= peak_d;
      if (done_q) begin
        left_q  <= hold_q;
        right_q <= shift_q;
      end
    end
  end

  assign oAUD_BCK     = bck_q;
  assign oAUD_ADCLRCK = lrck_q;
  assign oLEFT        = left_q;
  assign oRIGHT       = right_q;
  assign oValid       = valid_q;
  assign oPeak        = peak_q;

endmodule

// File: tb/tb_adio_adc_rx.sv
// tb_adio_adc_rx: exercises adio_adc_rx with its default parameters.
// A codec model serializes the word tables. The expected outputs come from edge-count arithmetic.
// The test ends with a summary line.

module tb_adio_adc_rx;

  logic        clk;
  logic        rst_n;
  logic        adcdat;
  logic        clr;
  logic        bck;
  logic        lrck;
  logic [15:0] left;
  logic [15:0] right;
  logic        valid;
  logic [14:0] peak;

  adio_adc_rx dut (
    .iCLK_18_4   (clk),
    .iRST_N      (rst_n),
    .iAUD_ADCDAT (adcdat),
    .iPeak_clr   (clr),
    .oAUD_BCK    (bck),
    .oAUD_ADCLRCK(lrck),
    .oLEFT       (left),
    .oRIGHT      (right),
    .oValid      (valid),
    .oPeak       (peak)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int fails  = 0;

  // Number of rising edges since reset was released. It stays at 0 while reset is held.
  int n = 0;

  // Words the codec sends for frame k, counted from the last reset release.
  logic [15:0] lw [8];
  logic [15:0] rw [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic int mag(input logic [15:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // Codec: after every falling clock edge, drive the bit for the next BCK rising edge.
  // BCK rises on edges 6, 18, 30, and so on. Each 192-edge half-frame holds 16 bits, MSB first.
  // Half-frame 0 is the partial one after reset, so it carries random bits.
  initial begin : codec
    int s;
    int h;
    int idx;
    logic [15:0] w;
    adcdat = 1'b0;
    forever begin
      @(negedge clk);
      s = ((n % 12) < 6) ? (n - (n % 12) + 6) : (n - (n % 12) + 18);
      h = s / 192;
      idx = (s % 192) / 12;
      if (h == 0) begin
        adcdat = 1'($urandom);
      end else begin
        w = (h % 2 == 1) ? lw[((h - 1) / 2) % 8] : rw[((h - 2) / 2) % 8];
        adcdat = w[15 - idx];
      end
    end
  end

  // Reference model and per-cycle compare
  int m_left  = 0;
  int m_right = 0;
  int m_peak  = 0;
  int m_valid = 0;

  always @(posedge clk) begin : compare
    logic clr_s;
    int k;
    int nm;
    clr_s = clr;
    #1;
    if (!rst_n) begin
      n = 0;
      m_left = 0;
      m_right = 0;
      m_peak = 0;
      m_valid = 0;
    end else begin
      n++;
      // Frame k is published one clock after its last right-channel bit, at edge 571 + 384k.
      m_valid = (n >= 571 && ((n - 571) % 384) == 0) ? 1 : 0;
      if (m_valid == 1) begin
        k = ((n - 571) / 384) % 8;
        m_left = lw[k];
        m_right = rw[k];
        nm = (mag(lw[k]) > mag(rw[k])) ? mag(lw[k]) : mag(rw[k]);
        if (clr_s) m_peak = nm;
        else if (nm > m_peak) m_peak = nm;
      end else if (clr_s) begin
        m_peak = 0;
      end
    end
    check("bck", 32'(bck), 32'((n / 6) % 2));
    check("lrck", 32'(lrck), 32'((n / 192) % 2));
    check("valid", 32'(valid), 32'(m_valid));
    check("left", 32'(left), 32'(m_left));
    check("right", 32'(right), 32'(m_right));
    check("peak", 32'(peak), 32'(m_peak));
  end

  // Waits on falling edges until edge t has happened. A timeout counts as a failed comparison.
  task automatic wait_n(input int t);
    int guard;
    guard = 0;
    while (n < t && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_edge", 32'(n), 32'(t));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill(input logic [15:0] l, input logic [15:0] r);
    for (int i = 0; i < 8; i++) begin
      lw[i] = l;
      rw[i] = r;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      lw[i] = 16'($urandom);
      rw[i] = 16'($urandom);
    end
  endtask

  initial begin : main
    rst_n = 1'b0;
    clr = 1'b0;
    fill(16'h0000, 16'h0000);
    repeat (3) @(negedge clk);

    // Silent input: check the clock timing and the first strobe
    do_reset();
    wait_n(5);   check("bck_pre", 32'(bck), 32'd0);
    wait_n(6);   check("bck_rise", 32'(bck), 32'd1);
    wait_n(191); check("lrck_pre", 32'(lrck), 32'd0);
    wait_n(192); check("lrck_rise", 32'(lrck), 32'd1);
    wait_n(384); check("lrck_fall", 32'(lrck), 32'd0);
    wait_n(570); check("no_valid_570", 32'(valid), 32'd0);
    wait_n(571); check("first_valid", 32'(valid), 32'd1);
    check("zero_left", 32'(left), 32'h0);
    check("zero_right", 32'(right), 32'h0);
    wait_n(572); check("valid_one_cycle", 32'(valid), 32'd0);
    wait_n(955); check("second_valid", 32'(valid), 32'd1);

    // Full-scale words
    fill(16'h8000, 16'h7FFF);
    do_reset();
    wait_n(955);
    check("fs_left", 32'(left), 32'h8000);
    check("fs_right", 32'(right), 32'h7FFF);
    check("fs_peak", 32'(peak), 32'h7FFF);
    wait_n(1339);

    // Peak hold, clear, and re-arm
    fill(16'h0001, 16'h0002);
    lw[0] = 16'h1234;
    rw[0] = 16'hFFFE;
    do_reset();
    wait_n(571);  check("peak_1234", 32'(peak), 32'h1234);
    wait_n(955);  check("peak_held", 32'(peak), 32'h1234);
    wait_n(1000); clr = 1'b1;
    wait_n(1001); clr = 1'b0;
    check("peak_cleared", 32'(peak), 32'h0);
    wait_n(1339); check("peak_rearm", 32'(peak), 32'h0002);

    // Clear held across an update: the new pair wins over the old peak
    fill(16'hFF00, 16'h0010);
    lw[0] = 16'h7000;
    rw[0] = 16'h0000;
    do_reset();
    wait_n(950); check("peak_7000", 32'(peak), 32'h7000);
    clr = 1'b1;
    wait_n(955); check("clr_with_valid", 32'(peak), 32'h0100);
    clr = 1'b0;
    wait_n(956); check("clr_with_valid_hold", 32'(peak), 32'h0100);

    // Reset in the middle of the first right half-frame
    fill_random();
    do_reset();
    wait_n(450);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_n(570);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_left", 32'(left), 32'h0);
    check("mid_rst_right", 32'(right), 32'h0);
    wait_n(571); check("mid_rst_first_valid", 32'(valid), 32'd1);
    wait_n(1723);

    // Random words with occasional peak clears
    fill_random();
    do_reset();
    while (n < 2100) begin
      @(negedge clk);
      clr = ($urandom_range(0, 59) == 0);
    end
    clr = 1'b0;
    wait_n(2101);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/adio_adc_rx.md
ADIO_ADC_RX -- requirements
Module: adio_adc_rx

Interface
REQ-001 Parameter REF_CLK, default 18432000, SHALL be the reference clock frequency in Hz.
REQ-002 Parameter SAMPLE_RATE, default 48000, SHALL be the frame rate in Hz.
REQ-003 Parameter DATA_WIDTH, default 16, SHALL be the bits per channel word.
REQ-004 Parameter CHANNEL_NUM, default 2, SHALL be the channels per frame.
REQ-005 iCLK_18_4  input  1  SHALL be the system clock; all logic is rising-edge synchronous to it.
REQ-006 iRST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 iAUD_ADCDAT  input  1  SHALL be the codec ADC serial data, MSB first.
REQ-008 iPeak_clr  input  1  SHALL be a synchronous clear of the peak meter.
REQ-009 oAUD_BCK  output  1  SHALL be the generated bit clock to the codec.
REQ-010 oAUD_ADCLRCK  output  1  SHALL be the generated ADC frame clock: 1 = left, 0 = right.
REQ-011 oLEFT  output  16  SHALL be the last complete left word, two's complement.
REQ-012 oRIGHT  output  16  SHALL be the last complete right word, two's complement.
REQ-013 oValid  output  1  SHALL be a one-cycle strobe marking a new oLEFT/oRIGHT pair.
REQ-014 oPeak  output  15  SHALL be the peak-hold magnitude over both channels.

Function
REQ-015 BCK divider SHALL toggle oAUD_BCK when its count reaches REF_CLK/(SAMPLE_RATE*DATA_WIDTH*CHANNEL_NUM*2)-1, then wrap to 0; with defaults, toggle every 6 clocks.
REQ-016 LRCK divider SHALL toggle oAUD_ADCLRCK when its count reaches REF_CLK/(SAMPLE_RATE*2)-1, then wrap to 0; with defaults, toggle every 192 clocks. The result is 32 BCK periods per frame, and each LRCK edge coincides with a BCK falling edge.
REQ-017 A "sample edge" SHALL be the clock on which oAUD_BCK toggles 0->1.
REQ-018 iAUD_ADCDAT SHALL be sampled only on sample edges, using the value present before that clock edge.
REQ-019 Sampled bits SHALL shift into a 16-bit shift register MSB first (left-justified); the first sample edge after an LRCK toggle is the MSB.
REQ-020 A 5-bit bit counter SHALL clear on every LRCK toggle and increment on each sample edge.
REQ-021 Sample edges beyond DATA_WIDTH in a half-frame SHALL be ignored, with the counter saturating.
REQ-022 FSM states SHALL be SYNC, LEFT, RIGHT.
REQ-023 SYNC SHALL be entered from reset; SYNC->LEFT on the LRCK 0->1 toggle; LEFT->RIGHT on 1->0; RIGHT->LEFT on 0->1.
REQ-024 In SYNC, bits SHALL be discarded, so the partial right half-frame after reset never produces output.
REQ-025 On the DATA_WIDTH-th sample edge in LEFT, the shift result SHALL load a left holding register; oLEFT SHALL NOT change yet.
REQ-026 On the DATA_WIDTH-th sample edge in RIGHT, oLEFT SHALL load from the holding register and oRIGHT from the shift result, both registered, and oValid SHALL be 1 for exactly the next clock cycle.
REQ-027 A right half-frame SHALL NOT strobe oValid unless the preceding left half-frame completed all DATA_WIDTH bits; an incomplete left word SHALL be discarded.
REQ-028 Peak meter: on each oValid, the magnitude of each channel SHALL be computed as |x|, with -32768 saturating to 32767 (15 bits).
REQ-029 oPeak SHALL be set to the maximum of its current value and both magnitudes.
REQ-030 iPeak_clr=1 SHALL set oPeak to 0 on the next clock.
REQ-031 If iPeak_clr=1 coincides with an oValid update, oPeak SHALL take the max of the two new magnitudes only (clear wins over old value).
REQ-032 oLEFT, oRIGHT and oPeak SHALL hold between updates.

Reset
REQ-033 iRST_N=0 SHALL asynchronously clear both dividers, the bit counter, the shift register, the holding register, oAUD_BCK, oAUD_ADCLRCK, oLEFT, oRIGHT, oValid and oPeak to 0, and place the FSM in SYNC.
REQ-034 Reset mid-frame SHALL discard any partial word; no oValid SHALL occur until a complete left+right pair is received after release.
REQ-035 Counting clock edges from 1 after release: BCK first rises at edge 6; LRCK rises at edge 192 and falls at edge 384; the last right sample edge is 570; oValid is high between edges 571 and 572.

Verification
REQ-036 Release reset, iAUD_ADCDAT=0 -> oAUD_BCK period 12 clocks, oAUD_ADCLRCK period 384 clocks, first oValid at edge 571, oLEFT=oRIGHT=0x0000.
REQ-037 Serialize left 0x8000, right 0x7FFF every frame -> oLEFT=0x8000, oRIGHT=0x7FFF, oPeak=0x7FFF, one oValid per 384 clocks.
REQ-038 Left 0x1234, right 0xFFFE, then left 0x0001, right 0x0002 -> oPeak=0x1234 is held; iPeak_clr pulse -> oPeak=0x0000; next frame -> oPeak=0x0002.
REQ-039 iPeak_clr held through an oValid with left 0xFF00, right 0x0010, prior oPeak 0x7000 -> oPeak=0x0100.
REQ-040 Assert iRST_N=0 at edge 450 (mid right half), then release -> no oValid until edge 571 after release; outputs remain 0 until then.
REQ-041 Checker SHALL verify no oValid during SYNC, and exactly one oValid per frame thereafter.
